regfile_op_sequencer: RTL and testbench

//  Initiator for the 8x4 register file port set (2 async read ports, 1 sync write port).

---
 rtl/regfile_op_sequencer_pkg.sv | 32 +++
 rtl/regfile_op_sequencer_if.sv | 49 ++++
 rtl/regfile_op_sequencer_alu.sv | 48 ++++
 rtl/regfile_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_regfile_op_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer_pkg
// Shared definitions for the register-file operation sequencer:
//   - default data/address widths of the 8x4 register file
//   - ALU opcode constants (OP_ADD, OP_SUB, OP_AND, OP_MOV)
//   - 3-bit sequencer state encoding (S_IDLE .. S_DONE)
//   - small helper used to decode the command-ready condition
// -----------------------------------------------------------------------------
package regfile_op_sequencer_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // The sequencer only takes a new command while it is idle.
  function automatic logic is_idle(input state_e s);
    return (s == S_IDLE);
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer_if
// Bundles the command handshake and the register-file port set.
//   master : command source + register file (drives cmd_*, ReadDataA1/A2)
//   slave  : the sequencer (drives cmd_ready, read/write address+data,
//            WriteEnA, done, result, carry)
// Signals:
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/cmd_rd/rs1/rs2     command fields
//   ReadRegA1/A2, ReadDataA1/A2  two asynchronous read ports
//   WriteRegA/WriteDataA/WriteEnA synchronous write port
//   done/result/carry         retirement status
// -----------------------------------------------------------------------------
interface regfile_op_sequencer_if #(
  parameter int DATA_W = regfile_op_sequencer_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_op_sequencer_pkg::DEF_ADDR_W
);
  import regfile_op_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] ReadRegA1;
  logic [ADDR_W-1:0] ReadRegA2;
  logic [DATA_W-1:0] ReadDataA1;
  logic [DATA_W-1:0] ReadDataA2;
  logic [ADDR_W-1:0] WriteRegA;
  logic [DATA_W-1:0] WriteDataA;
  logic              WriteEnA;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, ReadDataA1, ReadDataA2,
    input  cmd_ready, ReadRegA1, ReadRegA2, WriteRegA, WriteDataA, WriteEnA,
           done, result, carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, ReadDataA1, ReadDataA2,
    output cmd_ready, ReadRegA1, ReadRegA2, WriteRegA, WriteDataA, WriteEnA,
           done, result, carry
  );

endinterface

// File: rtl/regfile_op_sequencer_alu.sv
// -----------------------------------------------------------------------------
// regfile_alu
// Combinational ALU for the sequencer.
//   i_a, i_b : operands read from the register file
//   i_op     : OP_ADD / OP_SUB / OP_AND / OP_MOV
//   o_y      : result (modulo 2**DATA_W)
//   o_c      : ADD carry-out, SUB borrow (a < b), 0 for AND/MOV
// -----------------------------------------------------------------------------
module regfile_alu
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_y,
  output logic              o_c
);

  // Opcode decode and arithmetic.
  always_comb begin
    o_y = {DATA_W{1'b0}};
    o_c = 1'b0;
    case (i_op)
      OP_ADD: begin
        {o_c, o_y} = {1'b0, i_a} + {1'b0, i_b};
      end
      OP_SUB: begin
        o_y = i_a - i_b;
        o_c = (i_a < i_b);
      end
      OP_AND: begin
        o_y = i_a & i_b;
        o_c = 1'b0;
      end
      OP_MOV: begin
        o_y = i_a;
        o_c = 1'b0;
      end
      default: begin
        o_y = {DATA_W{1'b0}};
        o_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer
// Accepts one ALU command per valid/ready handshake, reads rs1/rs2 from the
// register file, computes the result and writes it back to rd.
// Sequence: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE (only IDLE waits).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave view of regfile_op_sequencer_if (command handshake,
//          register-file read/write ports, done/result/carry)
// -----------------------------------------------------------------------------
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_op_sequencer_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;

  // Latched command fields; rs1/rs2 double as the read-port addresses, which
  // therefore change only on accept and hold their value afterwards.
  logic [1:0]        r_op,  w_op_nxt;
  logic [ADDR_W-1:0] r_rd,  w_rd_nxt;
  logic [ADDR_W-1:0] r_rs1, w_rs1_nxt;
  logic [ADDR_W-1:0] r_rs2, w_rs2_nxt;

  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_b, w_b_nxt;

  // Write address is separate from r_rd so the write port keeps its previous
  // value until the WRITE cycle of the next command.
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic              r_wr_en,   w_wr_en_nxt;
  logic              r_done,    w_done_nxt;
  logic [DATA_W-1:0] r_result,  w_result_nxt;
  logic              r_carry,   w_carry_nxt;

  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_c;

  regfile_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y),
    .o_c  (w_alu_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value decode for every datapath register.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_rd_nxt      = r_rd;
    w_rs1_nxt     = r_rs1;
    w_rs2_nxt     = r_rs2;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_wr_en_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_result_nxt  = r_result;
    w_carry_nxt   = r_carry;
    case (r_state)
      S_IDLE: begin
        // cmd_ready is 1 here, so valid alone completes the handshake.
        if (bus.cmd_valid) begin
          w_op_nxt    = bus.cmd_op;
          w_rd_nxt    = bus.cmd_rd;
          w_rs1_nxt   = bus.cmd_rs1;
          w_rs2_nxt   = bus.cmd_rs2;
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_a_nxt     = bus.ReadDataA1;
        w_b_nxt     = bus.ReadDataA2;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // Result, carry and the write-port drive all load at the same edge so
        // the write cycle presents exactly the value reported in result.
        w_result_nxt  = w_alu_y;
        w_carry_nxt   = w_alu_c;
        w_wr_addr_nxt = r_rd;
        w_wr_data_nxt = w_alu_y;
        w_wr_en_nxt   = 1'b1;
        w_state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= 2'b00;
      r_rd      <= {ADDR_W{1'b0}};
      r_rs1     <= {ADDR_W{1'b0}};
      r_rs2     <= {ADDR_W{1'b0}};
      r_a       <= {DATA_W{1'b0}};
      r_b       <= {DATA_W{1'b0}};
      r_wr_addr <= {ADDR_W{1'b0}};
      r_wr_data <= {DATA_W{1'b0}};
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= {DATA_W{1'b0}};
      r_carry   <= 1'b0;
    end else begin
      r_op      <= w_op_nxt;
      r_rd      <= w_rd_nxt;
      r_rs1     <= w_rs1_nxt;
      r_rs2     <= w_rs2_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_done    <= w_done_nxt;
      r_result  <= w_result_nxt;
      r_carry   <= w_carry_nxt;
    end
  end

  assign bus.cmd_ready  = is_idle(r_state);
  assign bus.ReadRegA1  = r_rs1;
  assign bus.ReadRegA2  = r_rs2;
  assign bus.WriteRegA  = r_wr_addr;
  assign bus.WriteDataA = r_wr_data;
  assign bus.WriteEnA   = r_wr_en;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.carry      = r_carry;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_op_sequencer
// Drives the sequencer against an 8x4 register file (reset contents r[i]=i),
// predicts each write with a shadow register model and a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_regfile_op_sequencer;
  import regfile_op_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0] rd;
    logic [3:0] y;
    logic       c;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];
  logic [3:0] exp_rf [8];
  logic [3:0] rf [8];

  regfile_op_sequencer_if #(.DATA_W(4), .ADDR_W(3)) bus ();

  regfile_op_sequencer #(.DATA_W(4), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: async reads, sync write, reset to r[i]=i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 4'(i);
    end else if (bus.WriteEnA) begin
      rf[bus.WriteRegA] <= bus.WriteDataA;
    end
  end

  assign bus.ReadDataA1 = rf[bus.ReadRegA1];
  assign bus.ReadDataA2 = rf[bus.ReadRegA2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_rf[i] = 4'(i);
    q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ra1"},  32'(bus.ReadRegA1),  32'd0);
    chk({tag, "_ra2"},  32'(bus.ReadRegA2),  32'd0);
    chk({tag, "_wa"},   32'(bus.WriteRegA),  32'd0);
    chk({tag, "_wd"},   32'(bus.WriteDataA), 32'd0);
    chk({tag, "_we"},   32'(bus.WriteEnA),   32'd0);
    chk({tag, "_done"}, 32'(bus.done),       32'd0);
    chk({tag, "_res"},  32'(bus.result),     32'd0);
    chk({tag, "_cy"},   32'(bus.carry),      32'd0);
  endtask

  // One command: handshake in IDLE, then check the four busy cycles.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input bit hold);
    logic [3:0] a, b, y;
    logic       c;
    exp_t       e;
    int         pulses;
    @(negedge clk);
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_we", 32'(bus.WriteEnA), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    a = exp_rf[rs1];
    b = exp_rf[rs2];
    case (op)
      OP_ADD:  {c, y} = {1'b0, a} + {1'b0, b};
      OP_SUB:  begin y = a - b; c = (a < b); end
      OP_AND:  begin y = a & b; c = 1'b0; end
      default: begin y = a;     c = 1'b0; end
    endcase
    exp_rf[rd] = y;
    q.push_back('{rd: rd, y: y, c: c});
    @(posedge clk);
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("busy_ready", 32'(bus.cmd_ready), 32'd0);
      if (k == 1) begin
        chk("read_a1", 32'(bus.ReadRegA1), 32'(rs1));
        chk("read_a2", 32'(bus.ReadRegA2), 32'(rs2));
      end
      if (bus.WriteEnA) pulses++;
      if (k == 3) begin
        chk("write_en", 32'(bus.WriteEnA), 32'd1);
        e = q.pop_front();
        chk("write_addr", 32'(bus.WriteRegA), 32'(e.rd));
        chk("write_data", 32'(bus.WriteDataA), 32'(e.y));
      end
      chk("done_timing", 32'(bus.done), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) begin
        chk("result", 32'(bus.result), 32'(y));
        chk("carry", 32'(bus.carry), 32'(c));
      end
      if (hold) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'($urandom_range(3, 0));
        bus.cmd_rd    = 3'($urandom_range(7, 0));
        bus.cmd_rs1   = 3'($urandom_range(7, 0));
        bus.cmd_rs2   = 3'($urandom_range(7, 0));
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    chk("one_pulse", 32'(pulses), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  // Accept a command, assert reset after n_busy busy cycles, check the drop.
  task automatic reset_during(input int n_busy, input string tag);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 3'd7;
    bus.cmd_rs1   = 3'd1;
    bus.cmd_rs2   = 3'd2;
    @(posedge clk);
    for (int k = 0; k < n_busy; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_zero_outputs(tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_hold_we"},   32'(bus.WriteEnA), 32'd0);
      chk({tag, "_hold_done"}, 32'(bus.done),     32'd0);
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk({tag, "_rel_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_rel_we"},    32'(bus.WriteEnA),  32'd0);
    chk({tag, "_rel_done"},  32'(bus.done),      32'd0);
    chk({tag, "_r7_kept"},   32'(rf[7]),         32'd7);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_rd    = 3'd0;
    bus.cmd_rs1   = 3'd0;
    bus.cmd_rs2   = 3'd0;
    model_reset();
    rst = 1'b0;
    #12;
    check_zero_outputs("por");
    chk("por_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: ADD r1 = r2 + r3 = 5
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0);
    chk("t1_r1", 32'(rf[1]), 32'd5);
    chk("t1_carry", 32'(bus.carry), 32'd0);

    // 2: SUB r0 = 2 - 5 = D with borrow; AND r6 = 7 & 5 = 5
    issue(OP_SUB, 3'd0, 3'd2, 3'd5, 1'b0);
    chk("t2_r0", 32'(rf[0]), 32'hD);
    chk("t2_borrow", 32'(bus.carry), 32'd1);
    issue(OP_AND, 3'd6, 3'd7, 3'd5, 1'b0);
    chk("t2_r6", 32'(rf[6]), 32'd5);
    chk("t2_carry", 32'(bus.carry), 32'd0);

    // 3: back-to-back RAW on r4: 7+5=12, then 12+7=19 -> 3 with carry
    issue(OP_ADD, 3'd4, 3'd7, 3'd5, 1'b0);
    chk("t3_r4a", 32'(rf[4]), 32'd12);
    issue(OP_ADD, 3'd4, 3'd4, 3'd7, 1'b0);
    chk("t3_r4b", 32'(rf[4]), 32'd3);
    chk("t3_carry", 32'(bus.carry), 32'd1);

    // 4: valid held high with changing fields while busy
    issue(OP_SUB, 3'd5, 3'd1, 3'd3, 1'b1);
    chk("t4_r5", 32'(rf[5]), 32'd2);
    issue(OP_MOV, 3'd2, 3'd4, 3'd0, 1'b1);
    chk("t4_r2", 32'(rf[2]), 32'd3);

    // 5: reset during READ, then MOV r3 = r6; reset during EXEC, then retry
    reset_during(1, "rst_read");
    issue(OP_MOV, 3'd3, 3'd6, 3'd0, 1'b0);
    chk("t5_r3", 32'(rf[3]), 32'd6);
    reset_during(2, "rst_exec");
    issue(OP_ADD, 3'd0, 3'd7, 3'd7, 1'b0);
    chk("t5_r0", 32'(rf[0]), 32'd14);
    chk("t5_q_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
